// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the write-only I2C target.
//   i2c_state_e   : target FSM state encoding
//   I2C_RW_WRITE  : R/W bit value for a write transfer
//   I2C_BYTE_W    : bits per I2C byte
package i2c_pkg;

   localparam int         I2C_BYTE_W   = 8;
   localparam logic       I2C_RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_BYTE1,
      ST_ACK1,
      ST_BYTE2,
      ST_ACK2,
      ST_WAIT_STOP
   } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: conditions one asynchronous I2C line for use on clk.
// A 2-flop synchronizer, an optional 3-sample majority filter and a delay
// flop for edge detection.
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (adds the majority
// filter, 2 extra clk latency, rejects single-clk pulses).
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset
//   line_in in  raw pad level
//   line_o  out conditioned level
//   rise_o  out one-clk pulse on conditioned rising edge
//   fall_o  out one-clk pulse on conditioned falling edge
module i2c_line_filter (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic line_o,
   output logic rise_o,
   output logic fall_o
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic prev_q, prev_d;
   logic line_s;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic tap1_q, tap1_d;
   logic tap2_q, tap2_d;
   logic maj_q, maj_d;
`endif

   always_comb begin
      sync1_d = line_in;
      sync2_d = sync1_q;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      tap1_d  = sync2_q;
      tap2_d  = tap1_q;
      // Two of three consecutive samples must agree, so a lone 1-clk
      // sample never reaches the output.
      maj_d   = (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
      line_s  = maj_q;
`else
      line_s  = sync2_q;
`endif
      prev_d  = line_s;
   end

   // Idle bus level is high; resetting to 1 avoids false edges on release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
         tap1_q  <= 1'b1;
         tap2_q  <= 1'b1;
         maj_q   <= 1'b1;
`endif
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
         tap1_q  <= tap1_d;
         tap2_q  <= tap2_d;
         maj_q   <= maj_d;
`endif
      end
   end

   always_comb begin
      line_o = line_s;
      rise_o = line_s & ~prev_q;
      fall_o = ~line_s & prev_q;
   end

endmodule

// File: rtl/i2c_target.sv
// i2c_target: write-only I2C target for a 3-byte codec register write
// (device address + W, then {reg_addr[6:0], val[8]}, val[7:0]).
// Optional feature macro: I2C_TARGET_GLITCH_FILTER_EN (majority filter on
// both bus lines, see i2c_line_filter).
// Ports:
//   clk          in  system clock (>= 8x SCLK)
//   reset        in  asynchronous active-high reset
//   i2c_sclk     in  bus clock pad
//   i2c_sdat_in  in  bus data pad
//   i2c_sdat_oe  out 1 = pull SDAT low (ACK)
//   wr_valid     out one-clk pulse per accepted write
//   wr_addr      out register address, held until next write
//   wr_data      out register value, held until next write
//   busy         out high while a transaction is in progress
//   state_dbg    out current FSM state
// Handshake: wr_valid is a single-cycle strobe with no back-pressure;
// wr_addr/wr_data are valid on the strobe cycle and stay stable after it.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h1A
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_sclk,
   input  logic       i2c_sdat_in,
   output logic       i2c_sdat_oe,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   output logic       busy,
   output i2c_state_e state_dbg
);

   logic scl_line, scl_rise, scl_fall;
   logic sda_line, sda_rise, sda_fall;
   logic start_det, stop_det;

   i2c_state_e              state_q, state_d;
   logic [2:0]              bit_cnt_q, bit_cnt_d;
   logic [I2C_BYTE_W-1:0]   shift_q, shift_d;
   logic [I2C_BYTE_W-1:0]   byte1_q, byte1_d;
   logic [I2C_BYTE_W-1:0]   shift_nxt;
   logic                    sdat_oe_q, sdat_oe_d;
   logic                    wr_valid_q, wr_valid_d;
   logic [6:0]              wr_addr_q, wr_addr_d;
   logic [8:0]              wr_data_q, wr_data_d;
   logic                    byte_done;

   i2c_line_filter u_scl (
      .clk    (clk),
      .rst    (reset),
      .line_in(i2c_sclk),
      .line_o (scl_line),
      .rise_o (scl_rise),
      .fall_o (scl_fall)
   );

   i2c_line_filter u_sda (
      .clk    (clk),
      .rst    (reset),
      .line_in(i2c_sdat_in),
      .line_o (sda_line),
      .rise_o (sda_rise),
      .fall_o (sda_fall)
   );

   assign start_det = sda_fall & scl_line;
   assign stop_det  = sda_rise & scl_line;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         byte1_q    <= '0;
         sdat_oe_q  <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         byte1_q    <= byte1_d;
         sdat_oe_q  <= sdat_oe_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      byte1_d    = byte1_q;
      sdat_oe_d  = sdat_oe_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      shift_nxt  = {shift_q[I2C_BYTE_W-2:0], sda_line};
      // The 8th rising edge of a byte completes it.
      byte_done  = scl_rise && (bit_cnt_q == 3'(I2C_BYTE_W - 1));

      if (start_det) begin
         // Also covers repeated START: any partial transfer is dropped.
         state_d   = ST_ADDR;
         bit_cnt_d = '0;
         shift_d   = '0;
         sdat_oe_d = 1'b0;
      end else if (stop_det) begin
         state_d   = ST_IDLE;
         bit_cnt_d = '0;
         sdat_oe_d = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR, ST_BYTE1, ST_BYTE2: begin
               if (scl_rise) begin
                  shift_d   = shift_nxt;
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
               if (byte_done) begin
                  bit_cnt_d = '0;
                  case (state_q)
                     ST_ADDR: begin
                        if (shift_nxt[7:1] == DEV_ADDR && shift_nxt[0] == I2C_RW_WRITE)
                           state_d = ST_ADDR_ACK;
                        else
                           state_d = ST_WAIT_STOP;
                     end
                     ST_BYTE1: begin
                        byte1_d = shift_nxt;
                        state_d = ST_ACK1;
                     end
                     default: state_d = ST_ACK2;
                  endcase
               end
            end
            ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
               // First falling edge (end of bit 8) drives ACK; the next
               // one (end of the ACK clock) releases and moves on.
               if (scl_fall) begin
                  if (!sdat_oe_q) begin
                     sdat_oe_d = 1'b1;
                  end else begin
                     sdat_oe_d = 1'b0;
                     case (state_q)
                        ST_ADDR_ACK: state_d = ST_BYTE1;
                        ST_ACK1:     state_d = ST_BYTE2;
                        default: begin
                           state_d    = ST_WAIT_STOP;
                           wr_valid_d = 1'b1;
                           wr_addr_d  = byte1_q[7:1];
                           wr_data_d  = {byte1_q[0], shift_q};
                        end
                     endcase
                  end
               end
            end
            default: ;  // IDLE and WAIT_STOP ignore bus bits
         endcase
      end
   end

   // Outputs
   always_comb begin
      i2c_sdat_oe = sdat_oe_q;
      wr_valid    = wr_valid_q;
      wr_addr     = wr_addr_q;
      wr_data     = wr_data_q;
      busy        = (state_q != ST_IDLE);
      state_dbg   = state_q;
   end

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;
   import i2c_pkg::*;

   localparam int QCLK = 5;  // clk cycles per quarter SCLK period

   logic       clk;
   logic       reset;
   logic       scl_m;
   logic       sda_m;
   logic       sda_pad;
   logic       i2c_sdat_oe;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic       busy;
   i2c_state_e state_dbg;

   int checks   = 0;
   int failures = 0;
   int wv_cnt   = 0;
   logic oe_seen = 1'b0;
   logic glitch_en = 1'b0;
   logic [15:0] exp_q[$];
   logic [6:0] last_addr = '0;
   logic [8:0] last_data = '0;

   // Open-drain bus: either side may pull SDAT low.
   assign sda_pad = sda_m & ~i2c_sdat_oe;

   i2c_target dut (
      .clk        (clk),
      .reset      (reset),
      .i2c_sclk   (scl_m),
      .i2c_sdat_in(sda_pad),
      .i2c_sdat_oe(i2c_sdat_oe),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .busy       (busy),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (i2c_sdat_oe) oe_seen = 1'b1;
      if (wr_valid === 1'b1) begin
         wv_cnt++;
         if (exp_q.size() == 0) begin
            chk("wr_unexpected", 32'd1, 32'd0);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(wr_addr), 32'(e[15:9]));
            chk("wr_data", 32'(wr_data), 32'(e[8:0]));
         end
      end
   end

   // driver tasks
   task automatic wq();
      repeat (QCLK) @(posedge clk);
      #2;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b0; wq();
      scl_m = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq();
      scl_m = 1'b1; wq();
      sda_m = 1'b1; wq();
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sda_m = b[i];
         wq();
         scl_m = 1'b1;
         wq();
         if (glitch_en && b[i]) begin
            @(posedge clk); #2 sda_m = 1'b0;
            @(posedge clk); #2 sda_m = 1'b1;
         end
         wq();
         scl_m = 1'b0;
         wq();
      end
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      send_bits(b, 8);
      sda_m = 1'b1;
      wq();
      scl_m = 1'b1;
      wq();
      ack = ~sda_pad;
      wq();
      scl_m = 1'b0;
      wq();
   endtask

   // reference model: expected write entry for a 3-byte write
   function automatic logic [15:0] model_wr(input logic [7:0] b1, input logic [7:0] b2);
      return {b1[7:1], b1[0], b2};
   endfunction

   function automatic logic addr_ok(input logic [7:0] b0);
      return (b0[7:1] == 7'h1A) && (b0[0] == 1'b0);
   endfunction

   initial begin
      logic ack;
      int   wv0;

      reset = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_oe", 32'(i2c_sdat_oe), 32'd0);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;
      wq();

      // full write
      wv0 = wv_cnt;
      exp_q.push_back(model_wr(8'h0F, 8'h9A));
      i2c_start();
      chk("t1_busy", 32'(busy), 32'd1);
      send_byte(8'h34, ack); chk("t1_ack0", 32'(ack), 32'd1);
      send_byte(8'h0F, ack); chk("t1_ack1", 32'(ack), 32'd1);
      send_byte(8'h9A, ack); chk("t1_ack2", 32'(ack), 32'd1);
      chk("t1_wv_count", 32'(wv_cnt - wv0), 32'd1);
      chk("t1_addr_val", 32'(wr_addr), 32'h07);
      chk("t1_data_val", 32'(wr_data), 32'h19A);
      i2c_stop();
      chk("t1_busy_stop", 32'(busy), 32'd0);
      last_addr = 7'h07; last_data = 9'h19A;

      // address mismatch
      wv0 = wv_cnt; oe_seen = 1'b0;
      i2c_start();
      send_byte(8'h3A, ack); chk("t2_ack0", 32'(ack), 32'd0);
      send_byte(8'h55, ack); chk("t2_ack1", 32'(ack), 32'd0);
      chk("t2_busy", 32'(busy), 32'd1);
      i2c_stop();
      chk("t2_oe_never", 32'(oe_seen), 32'd0);
      chk("t2_wv_count", 32'(wv_cnt - wv0), 32'd0);
      chk("t2_busy_stop", 32'(busy), 32'd0);

      // read bit set
      wv0 = wv_cnt;
      i2c_start();
      send_byte(8'h35, ack); chk("t3_ack0", 32'(ack), 32'd0);
      chk("t3_state", 32'(state_dbg), 32'(ST_WAIT_STOP));
      send_byte(8'h0F, ack); chk("t3_ack1", 32'(ack), 32'd0);
      i2c_stop();
      chk("t3_wv_count", 32'(wv_cnt - wv0), 32'd0);

      // STOP after byte1 discards, then a full write
      wv0 = wv_cnt;
      i2c_start();
      send_byte(8'h34, ack);
      send_byte(8'h0F, ack);
      i2c_stop();
      chk("t4_abort_wv", 32'(wv_cnt - wv0), 32'd0);
      chk("t4_addr_held", 32'(wr_addr), 32'(last_addr));
      exp_q.push_back(model_wr(8'h12, 8'h01));
      i2c_start();
      send_byte(8'h34, ack);
      send_byte(8'h12, ack);
      send_byte(8'h01, ack); chk("t4_ack2", 32'(ack), 32'd1);
      i2c_stop();
      chk("t4_wv_count", 32'(wv_cnt - wv0), 32'd1);
      chk("t4_addr_val", 32'(wr_addr), 32'h09);
      chk("t4_data_val", 32'(wr_data), 32'h001);
      last_addr = 7'h09; last_data = 9'h001;

      // repeated START in the middle of byte2
      wv0 = wv_cnt;
      i2c_start();
      send_byte(8'h34, ack);
      send_byte(8'h0F, ack);
      send_bits(8'hA5, 3);
      exp_q.push_back(model_wr(8'h1E, 8'h00));
      i2c_start();
      send_byte(8'h34, ack); chk("t5_ack0", 32'(ack), 32'd1);
      send_byte(8'h1E, ack);
      send_byte(8'h00, ack);
      i2c_stop();
      chk("t5_wv_count", 32'(wv_cnt - wv0), 32'd1);
      chk("t5_addr_val", 32'(wr_addr), 32'h0F);
      chk("t5_data_val", 32'(wr_data), 32'h000);
      last_addr = 7'h0F; last_data = 9'h000;

      // randomized transactions against the model
      for (int t = 0; t < 16; t++) begin
         logic [7:0] b [4];
         int nb;
         logic m;
         b[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
         for (int i = 1; i < 4; i++) b[i] = 8'($urandom);
         nb = $urandom_range(1, 4);
         m = addr_ok(b[0]);
         wv0 = wv_cnt;
         if (m && nb >= 3) begin
            exp_q.push_back(model_wr(b[1], b[2]));
            last_addr = b[1][7:1];
            last_data = {b[1][0], b[2]};
         end
         i2c_start();
         for (int i = 0; i < nb; i++) begin
            send_byte(b[i], ack);
            chk("rnd_ack", 32'(ack), 32'(m && (i < 3)));
         end
         i2c_stop();
         chk("rnd_wv_count", 32'(wv_cnt - wv0), 32'(m && nb >= 3));
         chk("rnd_addr_held", 32'(wr_addr), 32'(last_addr));
         chk("rnd_data_held", 32'(wr_data), 32'(last_data));
         chk("rnd_busy_stop", 32'(busy), 32'd0);
      end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
      // 1-clk SDAT low glitches while SCLK is high must be ignored
      wv0 = wv_cnt;
      exp_q.push_back(model_wr(8'h35, 8'h77));
      glitch_en = 1'b1;
      i2c_start();
      send_byte(8'h34, ack); chk("gl_ack0", 32'(ack), 32'd1);
      send_byte(8'h35, ack); chk("gl_ack1", 32'(ack), 32'd1);
      send_byte(8'h77, ack); chk("gl_ack2", 32'(ack), 32'd1);
      glitch_en = 1'b0;
      i2c_stop();
      chk("gl_wv_count", 32'(wv_cnt - wv0), 32'd1);
      chk("gl_addr_val", 32'(wr_addr), 32'h1A);
      chk("gl_data_val", 32'(wr_data), 32'h177);
`endif

      // reset asserted while the target is driving ACK
      i2c_start();
      send_bits(8'h34, 8);
      sda_m = 1'b1;
      wq();
      chk("rstack_oe_before", 32'(i2c_sdat_oe), 32'd1);
      reset = 1'b1;
      #1;
      chk("rstack_oe", 32'(i2c_sdat_oe), 32'd0);
      chk("rstack_busy", 32'(busy), 32'd0);
      chk("rstack_addr", 32'(wr_addr), 32'd0);
      chk("rstack_data", 32'(wr_data), 32'd0);
      chk("rstack_state", 32'(state_dbg), 32'(ST_IDLE));
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      wq();
      i2c_stop();
      chk("rstack_busy_after", 32'(busy), 32'd0);

      repeat (10) @(posedge clk);
      #2;
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
